jk_excitation_driver: RTL and testbench

- Driver end of the JK flip-flop interface: a modulo-N up/down/load counter that computes per-bit J/K excitation for the next state, instead of consuming J/K.
- Presents J/K combinationally so an external bank of JK cells can be stepped in lockstep.
- Keeps an internal JK-model copy of the state.
- Checks the external bank's Q against the model and records a sticky mismatch.

---
 rtl/jk_pkg.sv | 32 +++
 rtl/jk_excite_bit.sv | 22 ++
 rtl/jk_excitation_driver.sv | 109 ++++++++++
 tb/tb_jk_excitation_driver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared encodings and the JK next-state rule for the excitation driver.
// Benches reuse jk_next to model an external JK bank.
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  function automatic logic jk_next(
    input logic q,
    input logic j,
    input logic k
  );
    logic r;
    case ({j, k})
      JK_HOLD: r = q;
      JK_RST:  r = 1'b0;
      JK_SET:  r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// One-bit JK excitation: which J/K moves q to d on the next edge.
// Unchanged bits always get hold so the bank sees no spurious activity.
module jk_excite_bit
  import jk_pkg::*;
(
  input  logic q,
  input  logic d,
  input  logic use_toggle,
  output logic j,
  output logic k
);

  always_comb begin
    {j, k} = JK_HOLD;
    if (q != d) begin
      if (use_toggle) {j, k} = JK_TGL;
      else if (d)     {j, k} = JK_SET;
      else            {j, k} = JK_RST;
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Modulo-N up/down/load counter that drives J/K for an external JK bank,
// keeps its own JK-model state and flags when the bank disagrees.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int MODULUS    = 10,
  parameter bit USE_TOGGLE = 1'b1,
  localparam int W = $clog2(MODULUS)
) (
  input  logic         Clock,
  input  logic         reset,
  input  logic         set,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic [W-1:0] load_data,
  input  logic [W-1:0] q_ext,
  input  logic         clr_err,
  output logic [W-1:0] J,
  output logic [W-1:0] K,
  output logic [W-1:0] Q,
  output logic         tc,
  output logic         load_err,
  output logic         mismatch
);

  localparam logic [W-1:0] MAX = W'(MODULUS - 1);

  logic [W-1:0] r_q;
  logic         r_tc;
  logic         r_le;
  logic         r_mis;

  logic [W-1:0] w_d;
  logic [W-1:0] w_j_raw;
  logic [W-1:0] w_k_raw;
  logic [W-1:0] w_qn;
  logic         w_up;
  logic         w_dn;
  logic         w_ld;
  logic         w_clamp;

  assign w_up    = en && (mode == MODE_UP);
  assign w_dn    = en && (mode == MODE_DOWN);
  assign w_ld    = en && (mode == MODE_LOAD);
  assign w_clamp = {1'b0, load_data} >= (W+1)'(MODULUS);

  always_comb begin
    w_d = r_q;
    if (set)
      w_d = MAX;
    else if (w_up)
      w_d = (r_q == MAX) ? '0 : r_q + W'(1);
    else if (w_dn)
      w_d = (r_q == '0) ? MAX : r_q - W'(1);
    else if (w_ld)
      w_d = w_clamp ? MAX : load_data;
  end

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    jk_excite_bit u_bit (
      .q          (r_q[gi]),
      .d          (w_d[gi]),
      .use_toggle (USE_TOGGLE),
      .j          (w_j_raw[gi]),
      .k          (w_k_raw[gi])
    );
  end

  assign J = reset ? w_j_raw : '0;
  assign K = reset ? w_k_raw : '0;

  // State advances only through the JK rule, exactly as the bank does
  always_comb begin
    w_qn = r_q;
    for (int i = 0; i < W; i++)
      w_qn[i] = jk_next(r_q[i], J[i], K[i]);
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_q   <= '0;
      r_tc  <= 1'b0;
      r_le  <= 1'b0;
      r_mis <= 1'b0;
    end else begin
      r_q  <= w_qn;
      r_tc <= !set && ((w_up && r_q == MAX) ||
                       (w_dn && r_q == '0));
      r_le <= !set && w_ld && w_clamp;
      if (q_ext != r_q)
        r_mis <= 1'b1;
      else if (clr_err)
        r_mis <= 1'b0;
    end
  end

  assign Q        = r_q;
  assign tc       = r_tc;
  assign load_err = r_le;
  assign mismatch = r_mis;

  a_jk_reaches_d: assert property (
    @(posedge Clock) disable iff (!reset) w_qn == w_d);

  a_no_toggle: assert property (
    @(posedge Clock) disable iff (!reset)
      USE_TOGGLE || ((J & K) == '0));

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: toggle and set/reset excitation variants side by side.
// q_ext is driven from the bench's own expected state.
module tb_jk_excitation_driver;
  import jk_pkg::*;

  logic       Clock;
  logic       reset;
  logic       set;
  logic       en;
  logic [1:0] mode;
  logic [3:0] load_data;
  logic [3:0] q_ext;
  logic       clr_err;

  logic [3:0] Jt, Kt, Qt;
  logic       tct, let_, mt;
  logic [3:0] Js, Ks, Qs;
  logic       tcs, les, ms;

  int checks = 0;
  int passed = 0;
  logic [3:0] eq;
  logic       stuck;

  jk_excitation_driver #(.MODULUS(10), .USE_TOGGLE(1'b1)) u_t (
    .Clock(Clock), .reset(reset), .set(set), .en(en), .mode(mode),
    .load_data(load_data), .q_ext(q_ext), .clr_err(clr_err),
    .J(Jt), .K(Kt), .Q(Qt), .tc(tct), .load_err(let_), .mismatch(mt)
  );

  jk_excitation_driver #(.MODULUS(10), .USE_TOGGLE(1'b0)) u_s (
    .Clock(Clock), .reset(reset), .set(set), .en(en), .mode(mode),
    .load_data(load_data), .q_ext(q_ext), .clr_err(clr_err),
    .J(Js), .K(Ks), .Q(Qs), .tc(tcs), .load_err(les), .mismatch(ms)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [3:0] model(
    input logic [3:0] q, input logic s, input logic e,
    input logic [1:0] m, input logic [3:0] ld
  );
    if (s) return 4'd9;
    if (!e || m == 2'b00) return q;
    if (m == 2'b01) return (q == 4'd9) ? 4'd0 : q + 4'd1;
    if (m == 2'b10) return (q == 4'd0) ? 4'd9 : q - 4'd1;
    return (ld >= 4'd10) ? 4'd9 : ld;
  endfunction

  task automatic step();
    logic [3:0] nq;
    nq = model(eq, set, en, mode, load_data);
    @(posedge Clock);
    #1;
    eq = nq;
    q_ext = stuck ? (eq | 4'b0001) : eq;
  endtask

  task automatic test_reset();
    checks++;
    if (Qt !== 4'd0 || Qs !== 4'd0) $display("FAIL rst_q got=%h/%h exp=0", Qt, Qs);
    else passed++;
    checks++;
    if ({tct, let_, mt, tcs, les, ms} !== 6'b0)
      $display("FAIL rst_flags got=%b exp=000000", {tct, let_, mt, tcs, les, ms});
    else passed++;
    set = 1'b1;
    #1;
    checks++;
    if ({Jt, Kt, Js, Ks} !== 16'h0) $display("FAIL rst_jk got=%h exp=0", {Jt, Kt, Js, Ks});
    else passed++;
    set = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_up();
    en = 1'b1;
    mode = 2'b01;
    for (int k = 0; k < 10; k++) begin
      if (k == 7) begin
        checks++;
        if (Jt !== 4'hF || Kt !== 4'hF) $display("FAIL up_jk_tgl got=%h/%h exp=f/f", Jt, Kt);
        else passed++;
        checks++;
        if (Js !== 4'b1000 || Ks !== 4'b0111) $display("FAIL up_jk_sr got=%b/%b exp=1000/0111", Js, Ks);
        else passed++;
      end
      step();
      checks++;
      if (Qt !== 4'((k + 1) % 10) || Qs !== Qt)
        $display("FAIL up_q k=%0d got=%0d/%0d exp=%0d", k, Qt, Qs, (k + 1) % 10);
      else passed++;
      checks++;
      if (tct !== (k == 9)) $display("FAIL up_tc k=%0d got=%b exp=%b", k, tct, (k == 9));
      else passed++;
    end
  endtask

  task automatic test_down();
    mode = 2'b10;
    step();
    checks++;
    if (Qt !== 4'd9 || tct !== 1'b1 || tcs !== 1'b1)
      $display("FAIL down_wrap got=q%0d tc%b exp=q9 tc1", Qt, tct);
    else passed++;
    checks++;
    if (Js !== 4'b0000 || Ks !== 4'b0001) $display("FAIL down_jk_sr got=%b/%b exp=0000/0001", Js, Ks);
    else passed++;
    checks++;
    if (Jt !== 4'b0001 || Kt !== 4'b0001) $display("FAIL down_jk_tgl got=%b/%b exp=0001/0001", Jt, Kt);
    else passed++;
    step();
    checks++;
    if (Qs !== 4'd8 || tcs !== 1'b0) $display("FAIL down_98 got=q%0d tc%b exp=q8 tc0", Qs, tcs);
    else passed++;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ((Js & Ks) !== 4'b0) $display("FAIL down_no_tgl got=%b exp=0000", Js & Ks);
      else passed++;
      step();
    end
  endtask

  task automatic test_load();
    mode = 2'b11;
    load_data = 4'd13;
    step();
    checks++;
    if (Qt !== 4'd9 || let_ !== 1'b1 || les !== 1'b1 || tct !== 1'b0)
      $display("FAIL load_clamp got=q%0d le%b tc%b exp=q9 le1 tc0", Qt, let_, tct);
    else passed++;
    load_data = 4'd5;
    step();
    checks++;
    if (Qt !== 4'd5 || let_ !== 1'b0 || tct !== 1'b0)
      $display("FAIL load_5 got=q%0d le%b tc%b exp=q5 le0 tc0", Qt, let_, tct);
    else passed++;
  endtask

  task automatic test_set();
    mode = 2'b11;
    load_data = 4'd3;
    step();
    mode = 2'b01;
    set = 1'b1;
    #1;
    checks++;
    if (Jt !== 4'b1010 || Kt !== 4'b1010) $display("FAIL set_jk_tgl got=%b/%b exp=1010/1010", Jt, Kt);
    else passed++;
    checks++;
    if (Js !== 4'b1000 || Ks !== 4'b0010) $display("FAIL set_jk_sr got=%b/%b exp=1000/0010", Js, Ks);
    else passed++;
    step();
    set = 1'b0;
    checks++;
    if (Qt !== 4'd9 || Qs !== 4'd9 || tct !== 1'b0)
      $display("FAIL set_q got=q%0d/%0d tc%b exp=q9 tc0", Qt, Qs, tct);
    else passed++;
  endtask

  task automatic test_set_reset();
    @(negedge Clock);
    reset = 1'b0;
    set = 1'b1;
    #1;
    checks++;
    if (Qt !== 4'd0 || Qs !== 4'd0 || {Jt, Kt, Js, Ks} !== 16'h0)
      $display("FAIL set_rst got=q%0d jk%h exp=q0 jk0", Qt, {Jt, Kt, Js, Ks});
    else passed++;
    #1;
    set = 1'b0;
    reset = 1'b1;
    eq = 4'd0;
    q_ext = 4'd0;
  endtask

  task automatic test_clean();
    en = 1'b1;
    mode = 2'b01;
    for (int k = 0; k < 20; k++) begin
      if (k == 12) mode = 2'b10;
      step();
      checks++;
      if (mt !== 1'b0 || ms !== 1'b0) $display("FAIL clean_mis k=%0d got=%b%b exp=00", k, mt, ms);
      else passed++;
    end
  endtask

  task automatic test_stuck();
    mode = 2'b11;
    load_data = 4'd4;
    step();
    mode = 2'b00;
    stuck = 1'b1;
    q_ext = eq | 4'b0001;
    step();
    checks++;
    if (mt !== 1'b1 || ms !== 1'b1) $display("FAIL stuck_set got=%b%b exp=11", mt, ms);
    else passed++;
    step();
    checks++;
    if (mt !== 1'b1) $display("FAIL stuck_hold got=%b exp=1", mt);
    else passed++;
    clr_err = 1'b1;
    step();
    checks++;
    if (mt !== 1'b1) $display("FAIL clr_vs_detect got=%b exp=1", mt);
    else passed++;
    stuck = 1'b0;
    q_ext = eq;
    step();
    checks++;
    if (mt !== 1'b0 || ms !== 1'b0) $display("FAIL clr got=%b%b exp=00", mt, ms);
    else passed++;
    clr_err = 1'b0;
    step();
    checks++;
    if (mt !== 1'b0) $display("FAIL clr_stay got=%b exp=0", mt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    mode = 2'b11;
    load_data = 4'd6;
    step();
    mode = 2'b00;
    stuck = 1'b1;
    q_ext = eq | 4'b0001;
    step();
    stuck = 1'b0;
    q_ext = eq;
    mode = 2'b01;
    checks++;
    if (Qt !== 4'd6 || mt !== 1'b1) $display("FAIL mid_pre got=q%0d m%b exp=q6 m1", Qt, mt);
    else passed++;
    @(negedge Clock);
    reset = 1'b0;
    #1;
    checks++;
    if (Qt !== 4'd0 || {Jt, Kt} !== 8'h0 || mt !== 1'b0 || tct !== 1'b0)
      $display("FAIL mid_rst got=q%0d jk%h m%b exp=q0 jk0 m0", Qt, {Jt, Kt}, mt);
    else passed++;
    #1;
    reset = 1'b1;
    eq = 4'd0;
    q_ext = 4'd0;
    step();
    checks++;
    if (Qt !== 4'd1) $display("FAIL mid_resume1 got=%0d exp=1", Qt);
    else passed++;
    step();
    checks++;
    if (Qt !== 4'd2 || mt !== 1'b0) $display("FAIL mid_resume2 got=q%0d m%b exp=q2 m0", Qt, mt);
    else passed++;
  endtask

  initial begin
    reset = 1'b0;
    set = 1'b0;
    en = 1'b0;
    mode = 2'b00;
    load_data = 4'd0;
    q_ext = 4'd0;
    clr_err = 1'b0;
    eq = 4'd0;
    stuck = 1'b0;
    #12;
    test_reset();
    test_up();
    test_down();
    test_load();
    test_set();
    test_set_reset();
    test_clean();
    test_stuck();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
